// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one 8-bit signed MAC neuron: y = ReLU(sum x[k]*w[k] + bias).
// Define NEURON_CTRL_SAT_EN for a saturating accumulator and a sticky sat flag.
module neuron_seq_ctrl #(
    parameter int N_MAX = 16,
    parameter int ACC_W = 20,
    localparam int LEN_W  = $clog2(N_MAX + 1),
    localparam int ADDR_W = $clog2(N_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              start_ready,
    input  logic [LEN_W-1:0]  len,
    input  logic [7:0]        bias,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        x_rdata,
    input  logic [7:0]        w_rdata,
    output logic [ACC_W-1:0]  y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              sat
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, BIAS, OUT} state_t;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         len_q, len_eff;
    logic signed [7:0]        bias_q;
    logic signed [ACC_W-1:0]  acc, acc_nxt, addend;
    logic signed [15:0]       prod;
    logic                     rd_vld_q, accept, last_addr, add_en;

    assign len_eff     = (len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : len;
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = (state == OUT);
    assign rd_en       = (state == RUN);
    assign accept      = start && start_ready && !abort;
    assign last_addr   = (LEN_W'(rd_addr) == len_q - LEN_W'(1));
    assign prod        = $signed(x_rdata) * $signed(w_rdata);

    // Read data lands one cycle after the strobe, so the MAC runs off rd_vld_q;
    // BIAS never overlaps a pending product because DRAIN issues no read.
    always_comb begin
        add_en = rd_vld_q || (state == BIAS);
        addend = rd_vld_q ? {{(ACC_W-16){prod[15]}}, prod}
                          : {{(ACC_W-8){bias_q[7]}}, bias_q};
    end

`ifdef NEURON_CTRL_SAT_EN
    logic signed [ACC_W:0] sum;
    logic                  ovf, sat_q;

    always_comb begin
        sum     = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
        ovf     = (sum[ACC_W] != sum[ACC_W-1]);
        acc_nxt = sum[ACC_W-1:0];
        if (ovf)
            acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           sat_q <= 1'b0;
        else if (accept)                      sat_q <= 1'b0;
        else if (add_en && ovf && !abort)     sat_q <= 1'b1;
    end

    assign sat = sat_q;
`else
    assign acc_nxt = acc + addend;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (len_eff == '0) ? BIAS : RUN;
            RUN:     if (last_addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = BIAS;
            BIAS:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            y        <= '0;
            rd_addr  <= '0;
            len_q    <= '0;
            bias_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_en && !abort;
            if (abort && state != IDLE) begin
                acc <= '0;
            end else if (accept) begin
                len_q   <= len_eff;
                bias_q  <= bias;
                acc     <= '0;
                rd_addr <= '0;
            end else begin
                if (state == RUN && !last_addr) rd_addr <= rd_addr + ADDR_W'(1);
                if (add_en)                     acc     <= acc_nxt;
                if (state == BIAS)              y       <= acc_nxt[ACC_W-1] ? '0 : acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Randomized + directed bench for neuron_seq_ctrl against a dot-product reference model.
module tb_neuron_seq_ctrl;

    logic        clk, rst_n;
    logic        start, start_ready, abort, rd_en, out_valid, out_ready, busy, sat;
    logic [4:0]  len;
    logic [7:0]  bias, x_rdata, w_rdata;
    logic [3:0]  rd_addr;
    logic [19:0] y;

    logic        start2, start_ready2, rd_en2, out_valid2, out_ready2, busy2, sat2;
    logic [4:0]  len2;
    logic [7:0]  bias2;
    logic [7:0]  x2 = 8'h80;
    logic [7:0]  w2 = 8'h80;
    logic [3:0]  rd_addr2;
    logic [17:0] y2;

    byte xm [16];
    byte wm [16];

    int n_chk = 0;
    int n_fail = 0;

    neuron_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .len(len), .bias(bias), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
        .x_rdata(x_rdata), .w_rdata(w_rdata), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .sat(sat)
    );

    neuron_seq_ctrl #(.N_MAX(16), .ACC_W(18)) dut18 (
        .clk(clk), .rst_n(rst_n), .start(start2), .start_ready(start_ready2),
        .len(len2), .bias(bias2), .abort(1'b0), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .x_rdata(x2), .w_rdata(w2), .y(y2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffers with one cycle of read latency
    always @(posedge clk) begin
        if (rd_en) begin
            x_rdata <= xm[rd_addr];
            w_rdata <= wm[rd_addr];
        end
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic issue(input int n, input int b);
        @(negedge clk);
        start = 1'b1; len = 5'(n); bias = 8'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts at the negedge of cycle 1; returns the cycle out_valid was first seen
    task automatic wait_out(output int cyc, output int nrd, output int bad);
        cyc = 1; nrd = 0; bad = 0;
        while (!out_valid && cyc < 60) begin
            if (rd_en) begin
                if (int'(rd_addr) != cyc - 1) bad++;
                nrd++;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic longint ref_y(input int n, input int b);
        int     neff = (n > 16) ? 16 : n;
        longint s = b;
        for (int k = 0; k < neff; k++) s += longint'(xm[k]) * longint'(wm[k]);
        return (s < 0) ? 0 : s;
    endfunction

    task automatic do_op(input string tag, input int n, input int b, output longint yv);
        int cyc, nrd, bad;
        int neff = (n > 16) ? 16 : n;
        issue(n, b);
        wait_out(cyc, nrd, bad);
        yv = longint'(y);
        chk({tag, "_lat"}, cyc, (neff == 0) ? 2 : neff + 3);
        chk({tag, "_y"}, yv, ref_y(n, b));
        chk({tag, "_rdcnt"}, nrd, neff);
        chk({tag, "_rdaddr"}, bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release"}, {out_valid, busy, start_ready}, 3'b001);
    endtask

    initial begin
        longint yv;
        int cyc, nrd, bad, seen, hit;

        rst_n = 1'b0; start = 0; len = 0; bias = 0; abort = 0; out_ready = 0;
        start2 = 0; len2 = 0; bias2 = 0; out_ready2 = 0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {start_ready, busy, out_valid, rd_en, sat}, 5'b10000);
        chk("reset_y_addr", {y, rd_addr}, 0);
        rst_n = 1'b1;

        xm[0] = 3; wm[0] = 2;
        do_op("t1", 1, 1, yv);
        chk("t1_const", yv, 7);

        xm[0] = 1; xm[1] = 2; xm[2] = 3; xm[3] = 4;
        wm[0] = 5; wm[1] = 6; wm[2] = 7; wm[3] = 8;
        do_op("t4", 4, -5, yv);
        chk("t4_const", yv, 65);

        xm[0] = -5; xm[1] = 1; wm[0] = 5; wm[1] = 1;
        do_op("relu", 2, 4, yv);
        chk("relu_const", yv, 0);

        do_op("len0a", 0, 100, yv);
        chk("len0a_const", yv, 100);
        do_op("len0b", 0, -128, yv);
        chk("len0b_const", yv, 0);

        // Backpressure: result held, second command dropped
        xm[0] = 3; wm[0] = 2;
        issue(1, 1);
        wait_out(cyc, nrd, bad);
        chk("bp_valid", out_valid, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; len = 5'd1; bias = 8'd50; end
            if (i == 3) start = 1'b0;
            if (y != 20'd7 || start_ready || !out_valid) seen++;
            @(negedge clk);
        end
        chk("bp_hold", seen, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", {out_valid, busy}, 0);
        seen = 0;
        repeat (4) begin
            if (busy || out_valid) seen++;
            @(negedge clk);
        end
        chk("bp_dropped", seen, 0);

        // Abort at rd_addr=2
        for (int k = 0; k < 4; k++) begin xm[k] = 8'(k + 1); wm[k] = 9; end
        issue(4, 0);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (rd_en && rd_addr == 4'd2) hit = 1;
            else @(negedge clk);
        end
        chk("abort_reach", hit, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, start_ready, rd_en}, 3'b010);
        seen = 0;
        repeat (8) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_out", seen, 0);
        xm[0] = 3; wm[0] = 2;
        do_op("post_abort", 1, 1, yv);
        chk("post_abort_const", yv, 7);

        // Reset mid-RUN
        issue(8, 10);
        repeat (2) @(negedge clk);
        chk("mid_run", {busy, rd_en}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", {start_ready, busy, out_valid, rd_en, sat}, 5'b10000);
        chk("rst_y_addr", {y, rd_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized operations
        for (int t = 0; t < 25; t++) begin
            int n, b;
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
            b = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < 16; k++) begin
                xm[k] = byte'($urandom_range(0, 255));
                wm[k] = byte'($urandom_range(0, 255));
            end
            do_op($sformatf("rnd%0d", t), n, b, yv);
        end

        // 18-bit accumulator overflow case
        @(negedge clk);
        start2 = 1'b1; len2 = 5'd16; bias2 = 8'd0;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!out_valid2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("ovf_lat", cyc, 19);
`ifdef NEURON_CTRL_SAT_EN
        chk("ovf_y", y2, 131071);
        chk("ovf_sat", sat2, 1);
`else
        chk("ovf_y", y2, 0);
        chk("ovf_sat", sat2, 0);
`endif
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        chk("ovf_release", {out_valid2, busy2, start_ready2}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
